sar_channel_scheduler: RTL and testbench

- Round-robin scheduler that time-shares one slow SAR tracking engine and comparator among NCH analog channels.
- Per request: arbitrates, drives the analog mux select, waits for settling, picks the search direction from the comparator, and kicks the engine with a single Inc or Dcr.
- Waits for the engine to return to idle, then posts the captured SAR word tagged with its channel number.
- Sits between the channel requesters and the SAR engine: drives the engine's Inc/Dcr, reads its StateP/SAROut/Compare.

---
 rtl/sar_channel_scheduler_if.sv | 33 +++
 rtl/sar_channel_scheduler.sv | 160 ++++++++++++++++
 tb/tb_sar_channel_scheduler.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/sar_channel_scheduler_if.sv
// Signal bundle between channel requesters, the SAR engine and the scheduler.
// master: scheduler side; slave: requesters/engine side.
interface sar_channel_scheduler_if #(
    parameter int DATA = 8,
    parameter int NCH  = 4,
    parameter int CHW  = 2
);
    logic [NCH-1:0]  req;
    logic [NCH-1:0]  grant;
    logic [CHW-1:0]  ch_sel;
    logic            compare;
    logic [1:0]      sar_state;
    logic [DATA-1:0] sar_out;
    logic            sar_inc;
    logic            sar_dcr;
    logic [DATA-1:0] result;
    logic [CHW-1:0]  result_ch;
    logic            result_valid;
    logic            busy;
    logic            timeout_err;

    modport master (
        input  req, compare, sar_state, sar_out,
        output grant, ch_sel, sar_inc, sar_dcr, result, result_ch,
               result_valid, busy, timeout_err
    );

    modport slave (
        output req, compare, sar_state, sar_out,
        input  grant, ch_sel, sar_inc, sar_dcr, result, result_ch,
               result_valid, busy, timeout_err
    );
endinterface

// File: rtl/sar_channel_scheduler.sv
// Round-robin scheduler sharing one SAR tracking engine among NCH channels.
// Optional watchdog abort enabled by defining SAR_TIMEOUT_EN.
module sar_channel_scheduler #(
    parameter int DATA    = 8,
    parameter int NCH     = 4,
    parameter int CHW     = 2,
    parameter int SETTLE  = 3,
    parameter int TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    sar_channel_scheduler_if.master bus
);
    localparam int          CW    = $clog2(SETTLE + 1);
    localparam int unsigned NCH_U = NCH;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_START, ST_BUSY} state_t;

    state_t          state, state_n;
    logic [CHW-1:0]  ptr, ptr_n, ch, ch_n, win, idx, ptr_next;
    logic [NCH-1:0]  grant, grant_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic            dir, dir_n, busy, busy_n, valid, valid_n, found;
    logic [DATA-1:0] result, result_n;
    logic [CHW-1:0]  result_ch, result_ch_n;
    logic            engine_idle;

    assign engine_idle = (bus.sar_state == 2'b00);
    assign ptr_next    = (ch == CHW'(NCH - 1)) ? '0 : ch + CHW'(1);

    // First requester at or above the pointer, wrapping at NCH-1.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NCH_U; i++) begin
            idx = CHW'((32'(ptr) + i) % NCH_U);
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

`ifdef SAR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd, wd_n;
    logic          tmo, tmo_n;
`endif

    always_comb begin
        state_n     = state;
        ptr_n       = ptr;
        ch_n        = ch;
        grant_n     = grant;
        cnt_n       = cnt;
        dir_n       = dir;
        busy_n      = busy;
        result_n    = result;
        result_ch_n = result_ch;
        valid_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (engine_idle && found) begin
                    grant_n      = '0;
                    grant_n[win] = 1'b1;
                    ch_n         = win;
                    busy_n       = 1'b1;
                    cnt_n        = CW'(SETTLE);
                    state_n      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                cnt_n = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    dir_n   = bus.compare;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (!engine_idle) state_n = ST_BUSY;
            end
            ST_BUSY: begin
                if (engine_idle) begin
                    result_n    = bus.sar_out;
                    result_ch_n = ch;
                    valid_n     = 1'b1;
                    ptr_n       = ptr_next;
                    grant_n     = '0;
                    busy_n      = 1'b0;
                    state_n     = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
`ifdef SAR_TIMEOUT_EN
        // Counter is zero outside START/BUSY, so entry to START always starts at 0.
        tmo_n = 1'b0;
        wd_n  = (state == ST_START || state == ST_BUSY) ? wd + TW'(1) : '0;
        if ((state == ST_START || state == ST_BUSY) && wd == TW'(TIMEOUT - 1)
            && !(state == ST_BUSY && engine_idle)) begin
            tmo_n   = 1'b1;
            wd_n    = '0;
            ptr_n   = ptr_next;
            grant_n = '0;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            ch        <= '0;
            grant     <= '0;
            cnt       <= '0;
            dir       <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            result_ch <= '0;
            valid     <= 1'b0;
`ifdef SAR_TIMEOUT_EN
            wd        <= '0;
            tmo       <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            ch        <= ch_n;
            grant     <= grant_n;
            cnt       <= cnt_n;
            dir       <= dir_n;
            busy      <= busy_n;
            result    <= result_n;
            result_ch <= result_ch_n;
            valid     <= valid_n;
`ifdef SAR_TIMEOUT_EN
            wd        <= wd_n;
            tmo       <= tmo_n;
`endif
        end
    end

    // Kick strobes drop combinationally once the engine leaves idle.
    assign bus.sar_inc      = (state == ST_START) && engine_idle && dir;
    assign bus.sar_dcr      = (state == ST_START) && engine_idle && !dir;
    assign bus.grant        = grant;
    assign bus.ch_sel       = ch;
    assign bus.busy         = busy;
    assign bus.result       = result;
    assign bus.result_ch    = result_ch;
    assign bus.result_valid = valid;
`ifdef SAR_TIMEOUT_EN
    assign bus.timeout_err  = tmo;
`else
    assign bus.timeout_err  = 1'b0;
`endif
endmodule

// File: tb/tb_sar_channel_scheduler.sv
// Directed-plus-random bench for sar_channel_scheduler with an engine stand-in
// and a round-robin reference model kept as a pointer plus the last posted result.
module tb_sar_channel_scheduler;
    localparam int DATA    = 8;
    localparam int NCH     = 4;
    localparam int CHW     = 2;
    localparam int SETTLE  = 3;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sar_channel_scheduler_if #(.DATA(DATA), .NCH(NCH), .CHW(CHW)) bus ();

    sar_channel_scheduler #(
        .DATA(DATA), .NCH(NCH), .CHW(CHW), .SETTLE(SETTLE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned ptr_m;
    logic [7:0]  last_res;
    int unsigned last_ch;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned pick(input int unsigned p, input logic [NCH-1:0] r);
        for (int unsigned k = 0; k < NCH; k++) begin
            int unsigned c;
            c = (p + k) % NCH;
            if (r[c[CHW-1:0]]) return c;
        end
        return 0;
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        check("rst_grant", bus.grant, 0);
        check("rst_ch_sel", bus.ch_sel, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_strobes", {bus.sar_inc, bus.sar_dcr}, 0);
        check("rst_valid", bus.result_valid, 0);
        check("rst_result", bus.result, 0);
        check("rst_result_ch", bus.result_ch, 0);
        check("rst_timeout", bus.timeout_err, 0);
        bus.req = '0;
        bus.sar_state = 2'b00;
        step();
        step();
        check("rst_no_valid", bus.result_valid, 0);
        rst = 1'b0;
        ptr_m = 0;
        last_res = '0;
        last_ch = 0;
    endtask

    // Caller guarantees DUT idle and engine state 00 in the current window.
    task automatic convert(input logic [NCH-1:0] rq, input logic [7:0] word,
                           input int unsigned hold, input int unsigned run,
                           input bit drop, input bit pass11, input int unsigned cmp_last);
        int unsigned ch;
        logic dirx;
        ch = pick(ptr_m, rq);
        bus.req = rq;
        step();
        check("grant", bus.grant, 32'(1) << ch);
        check("ch_sel", bus.ch_sel, ch);
        check("busy_set", bus.busy, 1);
        check("valid_once", bus.result_valid, 0);
        check("result_hold", bus.result, last_res);
        check("result_ch_hold", bus.result_ch, last_ch);
        dirx = 1'b0;
        for (int unsigned i = 1; i <= SETTLE; i++) begin
            if (i > 1) step();
            check("settle_no_strobe", {bus.sar_inc, bus.sar_dcr}, 0);
            bus.compare = 1'($urandom_range(0, 1));
            if (i == SETTLE && cmp_last < 2) bus.compare = cmp_last[0];
            dirx = bus.compare;
        end
        step();
        for (int unsigned h = 0; h <= hold; h++) begin
            check("start_strobe", {bus.sar_inc, bus.sar_dcr}, {dirx, ~dirx});
            check("start_ch_sel", bus.ch_sel, ch);
            bus.compare = 1'($urandom_range(0, 1));
            if (h < hold) step();
        end
        bus.sar_state = 2'b01;
        if (drop) bus.req = '0;
        #1;
        check("strobe_drop", {bus.sar_inc, bus.sar_dcr}, 0);
        for (int unsigned r = 0; r < run; r++) begin
            step();
            check("busy_run", bus.busy, 1);
            check("no_valid_run", bus.result_valid, 0);
            check("no_strobe_run", {bus.sar_inc, bus.sar_dcr}, 0);
            bus.sar_out = 8'($urandom);
            if (r == run - 1) begin
                bus.sar_state = 2'b00;
                bus.sar_out = word;
            end else if (pass11 && r == run / 2) begin
                bus.sar_state = 2'b11;
            end else begin
                bus.sar_state = 2'($urandom_range(1, 2));
            end
        end
        step();
        bus.sar_out = 8'($urandom);
        check("valid", bus.result_valid, 1);
        check("result", bus.result, word);
        check("result_ch", bus.result_ch, ch);
        check("grant_clear", bus.grant, 0);
        check("busy_clear", bus.busy, 0);
        check("timeout_quiet", bus.timeout_err, 0);
        ptr_m = (ch + 1) % NCH;
        last_res = word;
        last_ch = ch;
    endtask

    initial begin
        logic [NCH-1:0] rq;
        int unsigned ch;
        rst = 1'b0;
        bus.req = '0;
        bus.compare = 1'b0;
        bus.sar_state = 2'b00;
        bus.sar_out = '0;
        #1;
        apply_reset();

        // Single requester, Compare high, engine busy 10 cycles.
        convert(4'b0001, 8'h5A, 0, 10, 0, 0, 1);
        bus.req = '0;
        step();
        check("idle_gap_valid", bus.result_valid, 0);

        // All channels requesting continuously from a fresh pointer.
        apply_reset();
        for (int unsigned n = 0; n < 5; n++)
            convert(4'b1111, 8'($urandom), $urandom_range(0, 3), $urandom_range(1, 8), 0, 0, 2);
        bus.req = '0;
        step();

        // Compare low on the last settle cycle selects Dcr.
        convert(4'($urandom_range(1, 15)), 8'($urandom), 2, 4, 0, 0, 0);

        // Engine in init blocks arbitration; Req dropped mid-BUSY still completes.
        rq = 4'($urandom_range(1, 15));
        bus.req = rq;
        bus.sar_state = 2'b11;
        for (int unsigned n = 0; n < 4; n++) begin
            step();
            check("init_wait_grant", bus.grant, 0);
            check("init_wait_busy", bus.busy, 0);
        end
        bus.sar_state = 2'b00;
        convert(rq, 8'($urandom), 1, 5, 1, 1, 2);

        // Reset while the kick strobe is high.
        bus.req = 4'b1110;
        bus.compare = 1'b1;
        step();
        check("pre_rst_grant", bus.grant, 32'(1) << pick(ptr_m, 4'b1110));
        for (int unsigned i = 0; i < SETTLE; i++) step();
        check("pre_rst_inc", bus.sar_inc, 1);
        apply_reset();
        convert(4'b1011, 8'($urandom), 0, 3, 0, 0, 2);

`ifdef SAR_TIMEOUT_EN
        // Engine stuck in search: watchdog abort, then the next requester.
        rq = 4'($urandom_range(1, 15));
        ch = pick(ptr_m, rq);
        bus.req = rq;
        step();
        check("tmo_grant", bus.grant, 32'(1) << ch);
        for (int unsigned i = 0; i < SETTLE; i++) step();
        bus.sar_state = 2'b01;
        bus.req = '0;
        for (int unsigned k = 1; k <= TIMEOUT; k++) begin
            step();
            if (k < TIMEOUT) begin
                check("tmo_early", bus.timeout_err, 0);
                check("tmo_busy", bus.busy, 1);
            end else begin
                check("tmo_pulse", bus.timeout_err, 1);
                check("tmo_no_valid", bus.result_valid, 0);
                check("tmo_busy_clear", bus.busy, 0);
                check("tmo_grant_clear", bus.grant, 0);
                check("tmo_result", bus.result, last_res);
            end
        end
        step();
        check("tmo_one_cycle", bus.timeout_err, 0);
        ptr_m = (ch + 1) % NCH;
        bus.sar_state = 2'b00;
        convert(4'b1111, 8'($urandom), 0, 3, 0, 0, 2);
`else
        check("tmo_tied", bus.timeout_err, 0);
`endif

        // Randomized traffic against the round-robin model.
        for (int unsigned n = 0; n < 40; n++) begin
            int unsigned gap;
            gap = $urandom_range(0, 2);
            for (int unsigned g = 0; g < gap; g++) begin
                bus.req = '0;
                step();
                check("gap_valid", bus.result_valid, 0);
                check("gap_busy", bus.busy, 0);
            end
            convert(4'($urandom_range(1, 15)), 8'($urandom), $urandom_range(0, 3),
                    $urandom_range(1, 8), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 2);
        end
        bus.req = '0;
        step();
        check("final_valid", bus.result_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
